// File: rtl/vin_rcpwm_pkg.sv
// Shared types and constant helpers for the RC PWM input decoder family.
package vin_rcpwm_pkg;

    localparam int VALUE_W = 32;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        HIGH
    } state_t;

    // Microseconds to clock cycles, rounded down.
    function automatic logic [31:0] us_to_cyc(input longint clk_freq, input longint us);
        longint cyc;
        cyc = (clk_freq * us) / 64'd1000000;
        return cyc[31:0];
    endfunction

    // Milliseconds to clock cycles, rounded down.
    function automatic logic [31:0] ms_to_cyc(input longint clk_freq, input longint ms);
        longint cyc;
        cyc = (clk_freq * ms) / 64'd1000;
        return cyc[31:0];
    endfunction

endpackage

// File: rtl/rcpwm_sync.sv
// Two-flop synchronizer for an asynchronous pulse pin, with rise/fall
// detection and a ready flag that marks when level holds a real pin sample.
module rcpwm_sync (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ready
);

    logic       meta;
    logic       prev;
    logic [1:0] prime;

    // Sample the pin twice, keep one history bit, and track synchronizer fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
            prime <= 2'b00;
        end else begin
            // NOTE: non-blocking so every stage captures the previous stage's old value.
            meta  <= pin;
            level <= meta;
            prev  <= level;
            prime <= {prime[0], 1'b1};
        end
    end

    // The reset value of level is not a pin sample; ready says when it is.
    assign ready = prime[1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/vin_rcpwm_decoder.sv
// Measures RC PWM high time, validates it against bounds and reports the
// signed offset from centre in clock cycles, with a loss-of-signal timeout.
module vin_rcpwm_decoder
    import vin_rcpwm_pkg::*;
#(
    parameter int CLK_FREQ     = 48000000,
    parameter int PULSE_MIN_US = 800,
    parameter int PULSE_MAX_US = 2200,
    parameter int CENTER_US    = 1500,
    parameter int TIMEOUT_MS   = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      PWM,
    output logic signed [VALUE_W-1:0] rcValue,
    output logic                      rcValid,
    output logic                      rcStrobe,
    output logic                      rcError
);

    localparam logic [31:0] MIN_CYC   = us_to_cyc(CLK_FREQ, PULSE_MIN_US);
    localparam logic [31:0] MAX_CYC   = us_to_cyc(CLK_FREQ, PULSE_MAX_US);
    localparam logic [31:0] CTR_CYC   = us_to_cyc(CLK_FREQ, CENTER_US);
    localparam logic [31:0] TO_CYC    = ms_to_cyc(CLK_FREQ, TIMEOUT_MS);
    localparam logic [31:0] WIDTH_SAT = MAX_CYC + 32'd1;
    localparam logic [31:0] TO_LAST   = TO_CYC - 32'd1;

    logic        pwm_s;
    logic        pwm_rise;
    logic        pwm_fall;
    logic        sync_ready;
    state_t      state;
    logic [31:0] width;
    logic [31:0] to_cnt;
    logic        in_range;
    logic        accept;
    logic        reject;

    rcpwm_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (PWM),
        .level (pwm_s),
        .rise  (pwm_rise),
        .fall  (pwm_fall),
        .ready (sync_ready)
    );

    // Classify the pulse that ends (or overflows) this cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        in_range = 1'b0;
        accept   = 1'b0;
        reject   = 1'b0;
        in_range = (width >= MIN_CYC) && (width <= MAX_CYC);
        if (state == HIGH) begin
            accept = pwm_fall && in_range;
            reject = (pwm_fall && !in_range) || (!pwm_fall && width == WIDTH_SAT);
        end
    end

    // Pulse-measurement FSM with registered value, status, strobe and timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_LOW;
            width    <= '0;
            to_cnt   <= '0;
            rcValue  <= '0;
            rcValid  <= 1'b0;
            rcStrobe <= 1'b0;
            rcError  <= 1'b0;
        end else begin
            rcStrobe <= 1'b0;
            rcError  <= 1'b0;

            case (state)
                // Only a low pin that is a true sample ends a discarded pulse.
                WAIT_LOW: if (sync_ready && !pwm_s) state <= IDLE;
                IDLE: begin
                    if (pwm_rise) begin
                        state <= HIGH;
                        width <= 32'd1;
                    end
                end
                HIGH: begin
                    if (pwm_fall) begin
                        state <= IDLE;
                    end else if (width == WIDTH_SAT) begin
                        state <= WAIT_LOW;
                    end else begin
                        width <= width + 32'd1;
                    end
                end
                default: state <= WAIT_LOW;
            endcase

            // An accept in the same cycle as the timeout takes priority.
            if (accept) begin
                rcValue  <= $signed(width - CTR_CYC);
                rcValid  <= 1'b1;
                rcStrobe <= 1'b1;
                to_cnt   <= '0;
            end else begin
                if (reject) rcError <= 1'b1;
                if (to_cnt != TO_CYC) begin
                    to_cnt <= to_cnt + 32'd1;
                    if (to_cnt == TO_LAST) begin
                        rcValid <= 1'b0;
                        rcValue <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vin_rcpwm_decoder.sv
// Scoreboard bench for vin_rcpwm_decoder at 1 MHz (1 cycle = 1 us).
module tb_vin_rcpwm_decoder;

    localparam int MIN_W  = 800;
    localparam int MAX_W  = 2200;
    localparam int CTR_W  = 1500;
    localparam int TO_W   = 50000;
    localparam int LAT    = 3;

    typedef enum int {EV_STROBE, EV_ERROR, EV_TIMEOUT} ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       value;
        int       valid;
    } ev_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               PWM = 1'b0;
    logic signed [31:0] rcValue;
    logic               rcValid;
    logic               rcStrobe;
    logic               rcError;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    ev_t sb[$];
    logic prev_valid = 1'b0;

    // Reference model state: time and value of the most recent accept.
    bit  have_acc = 0;
    int  last_acc = 0;
    int  last_val = 0;

    vin_rcpwm_decoder #(
        .CLK_FREQ     (1000000),
        .PULSE_MIN_US (800),
        .PULSE_MAX_US (2200),
        .CENTER_US    (1500),
        .TIMEOUT_MS   (50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PWM      (PWM),
        .rcValue  (rcValue),
        .rcValid  (rcValid),
        .rcStrobe (rcStrobe),
        .rcError  (rcError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic sb_insert(input ev_t e);
        int idx;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    // Expected outcome of an n-cycle pulse whose rising pin edge follows posedge c_r.
    task automatic expect_pulse(input int n, input int c_r);
        ev_t e;
        int  t;
        if (n >= MIN_W && n <= MAX_W) begin
            t = c_r + n + LAT;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].kind == EV_TIMEOUT && sb[i].cyc >= t) sb.delete(i);
            e = '{kind: EV_STROBE, cyc: t, value: n - CTR_W, valid: 1};
            sb_insert(e);
            e = '{kind: EV_TIMEOUT, cyc: t + TO_W, value: 0, valid: 0};
            sb_insert(e);
            have_acc = 1;
            last_acc = t;
            last_val = n - CTR_W;
        end else begin
            // Over-long pulses are cut off once the width passes the maximum.
            t = (n > MAX_W) ? c_r + MAX_W + 1 + LAT : c_r + n + LAT;
            if (have_acc && t < last_acc + TO_W)
                e = '{kind: EV_ERROR, cyc: t, value: last_val, valid: 1};
            else
                e = '{kind: EV_ERROR, cyc: t, value: 0, valid: 0};
            sb_insert(e);
        end
    endtask

    task automatic pulse(input int n, input int gap);
        expect_pulse(n, cyc);
        PWM = 1'b1;
        repeat (n) @(negedge clk);
        PWM = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic handle(input ev_kind_t kind, input string name);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected %s at cycle %0d: got event, expected none", name, cyc);
        end else begin
            e = sb.pop_front();
            check({name, " kind"}, kind, e.kind);
            check({name, " cycle"}, cyc, e.cyc);
            check({name, " rcValue"}, rcValue, e.value);
            check({name, " rcValid"}, rcValid, e.valid);
        end
    endtask

    // Monitor: observe DUT events away from the active edge and score them.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (prev_valid && !rcValid) handle(EV_TIMEOUT, "timeout");
            if (rcError) handle(EV_ERROR, "error");
            if (rcStrobe) handle(EV_STROBE, "strobe");
            prev_valid <= rcValid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " rcValue"}, rcValue, 0);
        check({tag, " rcValid"}, rcValid, 0);
        check({tag, " rcStrobe"}, rcStrobe, 0);
        check({tag, " rcError"}, rcError, 0);
    endtask

    initial begin
        ev_t e;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);

        // Centre, extremes and inclusive bounds.
        pulse(1500, 100);
        pulse(2000, 100);
        pulse(1000, 100);
        pulse(800, 100);
        pulse(2200, 100);
        // Short reject keeps value/valid, then a normal pulse.
        pulse(1500, 100);
        pulse(500, 100);
        pulse(1800, 100);
        // Just outside the bounds.
        pulse(799, 50);
        pulse(2201, 50);
        // Stuck high: one error, then recovery.
        pulse(5000, 100);
        pulse(1500, 100);
        // Signal loss: 50 ms low after an accept.
        pulse(1500, 50100);
        pulse(1500, 100);

        // Reset 700 us into a pulse; the tail must be ignored.
        PWM = 1'b1;
        repeat (700) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid-pulse reset");
        sb.delete();
        have_acc = 0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (800) @(negedge clk);
        PWM = 1'b0;
        repeat (200) @(negedge clk);
        pulse(1200, 100);

        // Randomised widths and gaps, including minimal gaps.
        for (int i = 0; i < 5; i++)
            pulse($urandom_range(300, 2500), $urandom_range(1, 100));

        repeat (10) @(negedge clk);
        // Only a future signal-loss event may still be outstanding.
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (!(e.kind == EV_TIMEOUT && e.cyc > cyc)) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing event kind %0d: got nothing, expected at cycle %0d", e.kind, e.cyc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
